life_ctrl: RTL
==============

// Module: life_ctrl
// PURPOSE
//  Downstream consumer of the collision detector's lost flag on the 16x16 LED game board.
//  Converts raw collisions into game-level events:
//   - life accounting
//   - a post-hit invulnerable/flash period
//   - game-over latching
//   - freeze and blank controls for the pixel-update and display stages.
//  Collision is combinational and level-based; this block adds all state.
// PARAMETERS
//  MAX_LIVES  3    lives loaded on start (1..2**LIVES_W-1)
//  LIVES_W    2    width of lives counter
//  HIT_TICKS  8    tick pulses spent in HIT before play resumes (>=1)
//  SCORE_W    10   width of score counter (used only with LIFE_CTRL_SCORE_EN)
// PORTS
//  Clock      in   1        system clock, all state on posedge
//  reset      in   1        synchronous, active-low (0 = reset on next posedge)
//  tick       in   1        1-cycle game-step strobe from the frame divider
//  start      in   1        1-cycle start/restart strobe (debounced key)
//  lost       in   1        level: red/green pixel overlap this cycle
//  lives      out  LIVES_W  remaining lives
//  hit        out  1        1-cycle pulse per accepted collision
//  freeze     out  1        1 = upstream must hold pixel arrays (HIT, OVER, IDLE)
//  blank      out  1        1 = display blanked (flash phase)
//  game_over  out  1        1 while in OVER
//  score      out  SCORE_W  ticks survived; constant 0 without LIFE_CTRL_SCORE_EN
// BEHAVIOUR
//  - Reset (reset==0 at posedge), all outputs registered:
//    - state=IDLE, lives=0, hit=0, freeze=1, blank=0, game_over=0, score=0
//    - lost_q=0, hit_cnt=0
//  - Edge detect: lost_q <= lost every cycle in every state. rise = lost & ~lost_q.
//    - A held lost never re-triggers.
//  - FSM (one transition per cycle max):
//    - IDLE: freeze=1
//      - start -> PLAY, lives=MAX_LIVES, score=0, hit_cnt=0
//    - PLAY: freeze=0, blank=0
//      - rise -> hit=1 next cycle, lives=lives-1
//      - if lives==1 -> OVER, else -> HIT with hit_cnt=0
//      - rise and tick in same cycle: hit wins; no score increment
//    - HIT: freeze=1; rise ignored
//      - each tick: blank toggles, hit_cnt++
//      - tick with hit_cnt==HIT_TICKS-1 -> PLAY, blank=0
//    - OVER: freeze=1, game_over=1; each tick toggles blank
//      - start -> PLAY, lives=MAX_LIVES, score=0, blank=0, game_over=0
//      - start beats a simultaneous rise; that rise is discarded
//  - start in PLAY or HIT is ignored (no mid-game restart).
//  - Latency: rise at cycle N gives hit=1, updated lives and state at cycle N+1.
//    - hit is exactly 1 cycle.
//  - lives never underflows: the decrement only occurs from lives>=1 in PLAY.
//  - reset asserted mid-HIT or mid-OVER returns to IDLE next edge, all counters cleared.
// CONFIGURATION
//  LIFE_CTRL_SCORE_EN defined:
//    - score increments on each tick in PLAY (except on a hit cycle)
//    - saturates at 2**SCORE_W-1; cleared on entering PLAY from IDLE/OVER
//    - holds value in HIT/OVER
//  Not defined:
//    - no score register synthesized; score tied to 0
// TESTING
//  1. reset=0 2 cycles, then reset=1, start pulse -> PLAY, lives=3, freeze=0, blank=0, game_over=0.
//  2. PLAY, lost 0->1 held 5 cycles -> one hit pulse, lives=2, freeze=1;
//     8 ticks -> blank toggles 8x, back to PLAY, blank=0.
//  3. Three separated lost rises (each after HIT expires) -> lives 3->2->1->0;
//     third -> OVER, game_over=1, blank toggles per tick;
//     start -> PLAY, lives=3.
//  4. lost rise during HIT -> no hit, lives unchanged.
//     lost held from HIT into PLAY -> no new hit until it falls and rises.
//  5. OVER with start and lost rise same cycle -> PLAY, lives=3, hit=0.
//     reset=0 mid-HIT -> IDLE, lives=0 next edge.
//  6. LIFE_CTRL_SCORE_EN, SCORE_W=3: 10 ticks in PLAY -> score saturates at 7;
//     tick coincident with rise -> no increment.
//     Macro undefined -> score=0 always.

Source files
------------

// File: rtl/life_ctrl.sv
// life_ctrl: turns raw collision levels into lives, hit pulses, flash and game-over.
// Latency: one cycle from a lost rise to hit/lives/state; all outputs are registered.
// Backpressure: none; freeze tells upstream to hold the pixel arrays outside PLAY.
//
// Ports:
//   i_clk        system clock, all state on posedge
//   i_reset_n    synchronous active-low reset
//   i_tick       1-cycle game-step strobe
//   i_start      1-cycle start/restart strobe
//   i_lost       collision level from the detector
//   o_lives      remaining lives
//   o_hit        1-cycle pulse per accepted collision
//   o_freeze     1 outside PLAY (upstream holds pixel arrays)
//   o_blank      display blank during the flash phase
//   o_game_over  1 while in OVER
//   o_score      ticks survived (only when LIFE_CTRL_SCORE_EN is defined, else 0)
// Optional feature macro: LIFE_CTRL_SCORE_EN
module life_ctrl #(
    parameter int MAX_LIVES = 3,
    parameter int LIVES_W   = 2,
    parameter int HIT_TICKS = 8,
    parameter int SCORE_W   = 10
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_tick,
    input  logic               i_start,
    input  logic               i_lost,
    output logic [LIVES_W-1:0] o_lives,
    output logic               o_hit,
    output logic               o_freeze,
    output logic               o_blank,
    output logic               o_game_over,
    output logic [SCORE_W-1:0] o_score
);

    localparam int CNT_W = (HIT_TICKS > 1) ? $clog2(HIT_TICKS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_HIT  = 2'd2,
        S_OVER = 2'd3
    } state_t;

    state_t             r_state;
    logic [LIVES_W-1:0] r_lives;
    logic               r_hit;
    logic               r_freeze;
    logic               r_blank;
    logic               r_game_over;
    logic               r_lost_q;
    logic [CNT_W-1:0]   r_hit_cnt;

    state_t             w_state_nxt;
    logic [LIVES_W-1:0] w_lives_nxt;
    logic               w_hit_nxt;
    logic               w_blank_nxt;
    logic [CNT_W-1:0]   w_hit_cnt_nxt;
    logic               w_rise;

`ifdef LIFE_CTRL_SCORE_EN
    logic [SCORE_W-1:0] r_score;
    logic               w_score_inc;
    logic               w_score_clr;
`endif

    // A held lost level only counts once; lost_q tracks it in every state.
    assign w_rise = i_lost & ~r_lost_q;

    always_comb begin
        w_state_nxt   = r_state;
        w_lives_nxt   = r_lives;
        w_hit_nxt     = 1'b0;
        w_blank_nxt   = r_blank;
        w_hit_cnt_nxt = r_hit_cnt;
`ifdef LIFE_CTRL_SCORE_EN
        w_score_inc   = 1'b0;
        w_score_clr   = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt   = S_PLAY;
                    w_lives_nxt   = LIVES_W'(MAX_LIVES);
                    w_hit_cnt_nxt = '0;
                    w_blank_nxt   = 1'b0;
`ifdef LIFE_CTRL_SCORE_EN
                    w_score_clr   = 1'b1;
`endif
                end
            end
            S_PLAY: begin
                w_blank_nxt = 1'b0;
                if (w_rise) begin
                    // Hit takes priority over a coincident tick: no score step.
                    w_hit_nxt = 1'b1;
                    if (r_lives > LIVES_W'(1)) begin
                        w_lives_nxt   = r_lives - LIVES_W'(1);
                        w_state_nxt   = S_HIT;
                        w_hit_cnt_nxt = '0;
                    end else begin
                        // Last life (lives==0 cannot occur here; clamp anyway).
                        w_lives_nxt = '0;
                        w_state_nxt = S_OVER;
                    end
                end else if (i_tick) begin
`ifdef LIFE_CTRL_SCORE_EN
                    w_score_inc = 1'b1;
`endif
                end
            end
            S_HIT: begin
                if (i_tick) begin
                    w_blank_nxt   = ~r_blank;
                    w_hit_cnt_nxt = r_hit_cnt + CNT_W'(1);
                    if (r_hit_cnt == CNT_W'(HIT_TICKS - 1)) begin
                        w_state_nxt = S_PLAY;
                        w_blank_nxt = 1'b0;
                    end
                end
            end
            S_OVER: begin
                // Restart wins over any coincident rise, which is simply dropped.
                if (i_start) begin
                    w_state_nxt   = S_PLAY;
                    w_lives_nxt   = LIVES_W'(MAX_LIVES);
                    w_hit_cnt_nxt = '0;
                    w_blank_nxt   = 1'b0;
`ifdef LIFE_CTRL_SCORE_EN
                    w_score_clr   = 1'b1;
`endif
                end else if (i_tick) begin
                    w_blank_nxt = ~r_blank;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state     <= S_IDLE;
            r_lives     <= '0;
            r_hit       <= 1'b0;
            r_freeze    <= 1'b1;
            r_blank     <= 1'b0;
            r_game_over <= 1'b0;
            r_lost_q    <= 1'b0;
            r_hit_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_lives     <= w_lives_nxt;
            r_hit       <= w_hit_nxt;
            // freeze/game_over are decoded from the next state so they stay flops.
            r_freeze    <= (w_state_nxt != S_PLAY);
            r_blank     <= w_blank_nxt;
            r_game_over <= (w_state_nxt == S_OVER);
            r_lost_q    <= i_lost;
            r_hit_cnt   <= w_hit_cnt_nxt;
        end
    end

`ifdef LIFE_CTRL_SCORE_EN
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_score <= '0;
        end else if (w_score_clr) begin
            r_score <= '0;
        end else if (w_score_inc && (r_score != {SCORE_W{1'b1}})) begin
            r_score <= r_score + SCORE_W'(1);
        end
    end
    assign o_score = r_score;
`else
    assign o_score = '0;
`endif

    assign o_lives     = r_lives;
    assign o_hit       = r_hit;
    assign o_freeze    = r_freeze;
    assign o_blank     = r_blank;
    assign o_game_over = r_game_over;

endmodule
